// File: rtl/result_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : result_stream_reader
// Description : Drains packed result words from shared memory and streams
//               their bytes, low byte first, over a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module result_stream_reader #(
    parameter int ADR_W      = 8,
    parameter int WORD_BYTES = 4,
    parameter int CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADR_W-1:0]        base_adr,
    input  logic [CNT_W-1:0]        num_words,
    output logic                    mem_rd_en,
    output logic [ADR_W-1:0]        mem_rd_adr,
    input  logic [8*WORD_BYTES-1:0] mem_rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    localparam int c_DATA_W = 8 * WORD_BYTES;
    localparam int c_BC_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [c_BC_W-1:0] c_LAST_BYTE = c_BC_W'(WORD_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADR_W-1:0]    r_base;
    logic [CNT_W-1:0]    r_num_words;
    logic [CNT_W-1:0]    r_word_cnt;
    logic [c_BC_W-1:0]   r_byte_cnt;
    logic [c_DATA_W-1:0] r_word;
    logic                r_rd_en;
    logic [ADR_W-1:0]    r_rd_adr;
    logic                r_out_valid;
    logic [7:0]          r_out_data;
    logic                r_out_last;
    logic                r_busy;
    logic                r_done;

    logic                w_xfer;
    logic                w_last_word;
    logic                w_last_byte;
    logic [c_BC_W-1:0]   w_byte_nxt;
    logic [CNT_W-1:0]    w_word_nxt;
    logic [ADR_W-1:0]    w_nxt_adr;

    assign w_xfer      = r_out_valid & out_ready;
    assign w_last_word = (r_word_cnt == (r_num_words - CNT_W'(1)));
    assign w_last_byte = (r_byte_cnt == c_LAST_BYTE);
    assign w_byte_nxt  = r_byte_cnt + c_BC_W'(1);
    assign w_word_nxt  = r_word_cnt + CNT_W'(1);
    // Address wraps naturally at ADR_W bits.
    assign w_nxt_adr   = r_base + ADR_W'(w_word_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_num_words <= '0;
            r_word_cnt  <= '0;
            r_byte_cnt  <= '0;
            r_word      <= '0;
            r_rd_en     <= 1'b0;
            r_rd_adr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base      <= base_adr;
                        r_num_words <= num_words;
                        r_word_cnt  <= '0;
                        r_byte_cnt  <= '0;
                        r_busy      <= 1'b1;
                        if (num_words == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= S_READ;
                            r_rd_en  <= 1'b1;
                            r_rd_adr <= base_adr;
                        end
                    end
                end
                S_READ: begin
                    r_rd_en <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Read data arrives this cycle; byte 0 is presented straight from it.
                    r_word      <= mem_rd_data;
                    r_out_data  <= mem_rd_data[7:0];
                    r_out_valid <= 1'b1;
                    r_out_last  <= w_last_word && (c_LAST_BYTE == '0);
                    r_state     <= S_SEND;
                end
                S_SEND: begin
                    if (w_xfer) begin
                        if (w_last_byte) begin
                            r_byte_cnt  <= '0;
                            r_word_cnt  <= w_word_nxt;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            if (w_last_word) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state  <= S_READ;
                                r_rd_en  <= 1'b1;
                                r_rd_adr <= w_nxt_adr;
                            end
                        end else begin
                            r_byte_cnt <= w_byte_nxt;
                            r_out_data <= r_word[8*w_byte_nxt +: 8];
                            r_out_last <= w_last_word && (w_byte_nxt == c_LAST_BYTE);
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_rd_en  = r_rd_en;
    assign mem_rd_adr = r_rd_adr;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_result_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_stream_reader
// Description : Directed vector bench for result_stream_reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_adr;
    logic [7:0]  num_words;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_adr;
    logic [31:0] mem_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    result_stream_reader #(.ADR_W(8), .WORD_BYTES(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_adr    (base_adr),
        .num_words   (num_words),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_adr  (mem_rd_adr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_adr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rdy;
        logic       en;
        logic [7:0] adr;
        logic       vld;
        logic [7:0] dat;
        logic       lst;
        logic       bsy;
        logic       dn;
    } vec_t;

    vec_t vt [0:18];

    function automatic vec_t mk(input logic rdy, input logic en, input logic [7:0] adr,
                                input logic vld, input logic [7:0] dat, input logic lst,
                                input logic bsy, input logic dn);
        vec_t v;
        v.rdy = rdy; v.en = en; v.adr = adr; v.vld = vld;
        v.dat = dat; v.lst = lst; v.bsy = bsy; v.dn = dn;
        return v;
    endfunction

    // Entry i describes cycle k+1+(i-first) after start is sampled at edge k.
    task automatic run_table(input int first, input int last, input logic [7:0] b, input logic [7:0] n);
        base_adr  = b;
        num_words = n;
        start     = 1'b1;
        for (int i = first; i <= last; i++) begin
            cyc();
            start     = 1'b0;
            out_ready = vt[i].rdy;
            chk($sformatf("tbl%0d.rd_en", i), 32'(mem_rd_en), 32'(vt[i].en));
            if (vt[i].en) chk($sformatf("tbl%0d.rd_adr", i), 32'(mem_rd_adr), 32'(vt[i].adr));
            chk($sformatf("tbl%0d.valid", i), 32'(out_valid), 32'(vt[i].vld));
            if (vt[i].vld) chk($sformatf("tbl%0d.data", i), 32'(out_data), 32'(vt[i].dat));
            chk($sformatf("tbl%0d.last", i), 32'(out_last), 32'(vt[i].lst));
            chk($sformatf("tbl%0d.busy", i), 32'(busy), 32'(vt[i].bsy));
            chk($sformatf("tbl%0d.done", i), 32'(done), 32'(vt[i].dn));
        end
    endtask

    logic [7:0] rd_q [$];
    int         rd_cyc [$];
    logic [7:0] by_q [$];
    int         n_last;
    int         last_idx;

    // Runs one drain with ready held high; optionally pulses start at cycle poke_cyc.
    task automatic run_drain(input logic [7:0] b, input logic [7:0] n, input int budget,
                             input int poke_cyc, output int done_cyc);
        rd_q.delete(); rd_cyc.delete(); by_q.delete();
        n_last    = 0;
        last_idx  = -1;
        done_cyc  = -1;
        out_ready = 1'b1;
        base_adr  = b;
        num_words = n;
        start     = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            cyc();
            start = 1'b0;
            if (c == poke_cyc) begin
                start     = 1'b1;
                base_adr  = 8'h55;
                num_words = 8'h09;
            end
            if (mem_rd_en) begin
                rd_q.push_back(mem_rd_adr);
                rd_cyc.push_back(c);
            end
            if (out_valid && out_ready) begin
                by_q.push_back(out_data);
                if (out_last) begin
                    n_last++;
                    last_idx = by_q.size() - 1;
                end
            end
            if (done) begin
                done_cyc = c;
                cyc();
                start = 1'b0;
                chk("busy_after_done", 32'(busy), 32'd0);
                break;
            end
        end
        start = 1'b0;
        if (done_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got no done within %0d cycles, expected done", budget);
        end
    endtask

    int dc;

    initial begin
        rst = 1'b1; start = 1'b0; base_adr = '0; num_words = '0; out_ready = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 32'(a) * 32'h0101_0101 ^ 32'hA5A5_0000;
        mem[8'h20] = 32'h4433_2211;
        mem[8'h30] = 32'hDDCC_BBAA;
        mem[8'h10] = 32'h0403_0201;
        mem[8'h11] = 32'h0807_0605;
        mem[8'h12] = 32'h0C0B_0A09;
        mem[8'hFE] = 32'h1413_1211;
        mem[8'hFF] = 32'h2423_2221;
        mem[8'h00] = 32'h3433_3231;

        vt[0]  = mk(1, 1, 8'h20, 0, 8'h00, 0, 1, 0);
        vt[1]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 1, 0);
        vt[2]  = mk(1, 0, 8'h00, 1, 8'h11, 0, 1, 0);
        vt[3]  = mk(1, 0, 8'h00, 1, 8'h22, 0, 1, 0);
        vt[4]  = mk(1, 0, 8'h00, 1, 8'h33, 0, 1, 0);
        vt[5]  = mk(1, 0, 8'h00, 1, 8'h44, 1, 1, 0);
        vt[6]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 1, 1);
        vt[7]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        vt[8]  = mk(1, 1, 8'h30, 0, 8'h00, 0, 1, 0);
        vt[9]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 1, 0);
        vt[10] = mk(1, 0, 8'h00, 1, 8'hAA, 0, 1, 0);
        vt[11] = mk(0, 0, 8'h00, 1, 8'hBB, 0, 1, 0);
        vt[12] = mk(0, 0, 8'h00, 1, 8'hBB, 0, 1, 0);
        vt[13] = mk(0, 0, 8'h00, 1, 8'hBB, 0, 1, 0);
        vt[14] = mk(1, 0, 8'h00, 1, 8'hBB, 0, 1, 0);
        vt[15] = mk(1, 0, 8'h00, 1, 8'hCC, 0, 1, 0);
        vt[16] = mk(1, 0, 8'h00, 1, 8'hDD, 1, 1, 0);
        vt[17] = mk(1, 0, 8'h00, 0, 8'h00, 0, 1, 1);
        vt[18] = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);

        repeat (2) cyc();
        chk("reset.rd_en", 32'(mem_rd_en), 32'd0);
        chk("reset.rd_adr", 32'(mem_rd_adr), 32'd0);
        chk("reset.valid", 32'(out_valid), 32'd0);
        chk("reset.data", 32'(out_data), 32'd0);
        chk("reset.last", 32'(out_last), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        rst = 1'b0;
        cyc();

        run_table(0, 7, 8'h20, 8'd1);
        run_table(8, 18, 8'h30, 8'd1);

        run_drain(8'h10, 8'd3, 40, 0, dc);
        chk("three.done_cycle", 32'(dc), 32'd19);
        chk("three.num_reads", 32'(rd_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < rd_q.size(); i++) begin
            chk($sformatf("three.rd_adr%0d", i), 32'(rd_q[i]), 32'(8'h10 + i));
            chk($sformatf("three.rd_cyc%0d", i), 32'(rd_cyc[i]), 32'(1 + 6 * i));
        end
        chk("three.num_bytes", 32'(by_q.size()), 32'd12);
        for (int i = 0; i < 12 && i < by_q.size(); i++)
            chk($sformatf("three.byte%0d", i), 32'(by_q[i]), 32'(i + 1));
        chk("three.n_last", 32'(n_last), 32'd1);
        chk("three.last_idx", 32'(last_idx), 32'd11);

        run_drain(8'h40, 8'd0, 10, 0, dc);
        chk("zero.done_cycle", 32'(dc), 32'd1);
        chk("zero.num_reads", 32'(rd_q.size()), 32'd0);
        chk("zero.num_bytes", 32'(by_q.size()), 32'd0);

        // Wrap-around drain, with a start pulse while busy that must be ignored.
        run_drain(8'hFE, 8'd3, 40, 3, dc);
        chk("wrap.done_cycle", 32'(dc), 32'd19);
        chk("wrap.num_reads", 32'(rd_q.size()), 32'd3);
        if (rd_q.size() == 3) begin
            chk("wrap.rd_adr0", 32'(rd_q[0]), 32'hFE);
            chk("wrap.rd_adr1", 32'(rd_q[1]), 32'hFF);
            chk("wrap.rd_adr2", 32'(rd_q[2]), 32'h00);
        end
        chk("wrap.num_bytes", 32'(by_q.size()), 32'd12);
        if (by_q.size() == 12) begin
            chk("wrap.byte4", 32'(by_q[4]), 32'h21);
            chk("wrap.byte8", 32'(by_q[8]), 32'h31);
            chk("wrap.byte11", 32'(by_q[11]), 32'h34);
        end

        // Reset during the second word's SEND.
        out_ready = 1'b1; base_adr = 8'h10; num_words = 8'd3; start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            cyc();
            start = 1'b0;
        end
        chk("abort.pre_valid", 32'(out_valid), 32'd1);
        chk("abort.pre_data", 32'(out_data), 32'h05);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("abort.rd_en", 32'(mem_rd_en), 32'd0);
        chk("abort.rd_adr", 32'(mem_rd_adr), 32'd0);
        chk("abort.valid", 32'(out_valid), 32'd0);
        chk("abort.data", 32'(out_data), 32'd0);
        chk("abort.last", 32'(out_last), 32'd0);
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        cyc();
        chk("abort.no_done", 32'(done), 32'd0);

        run_drain(8'h20, 8'd1, 20, 0, dc);
        chk("fresh.done_cycle", 32'(dc), 32'd7);
        chk("fresh.num_reads", 32'(rd_q.size()), 32'd1);
        if (rd_q.size() == 1) chk("fresh.rd_adr", 32'(rd_q[0]), 32'h20);
        chk("fresh.num_bytes", 32'(by_q.size()), 32'd4);
        if (by_q.size() == 4) begin
            chk("fresh.byte0", 32'(by_q[0]), 32'h11);
            chk("fresh.byte3", 32'(by_q[3]), 32'h44);
        end

        // Reset and start in the same cycle: reset wins.
        rst = 1'b1; start = 1'b1; base_adr = 8'h20; num_words = 8'd1;
        cyc();
        rst = 1'b0; start = 1'b0;
        chk("rst_start.busy0", 32'(busy), 32'd0);
        cyc();
        chk("rst_start.busy1", 32'(busy), 32'd0);
        chk("rst_start.rd_en", 32'(mem_rd_en), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
